// File: rtl/inst_fetch.sv
// Instruction fetch stage: captures pc, issues one AXI4-Lite-style read, holds the word for the decoder.
// Optional read watchdog enabled by defining INST_FETCH_TIMEOUT_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter logic [31:0] NOP_INST       = 32'h0000_0013,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        fetch_req,
    input  logic        flush,
    input  logic        inst_ack,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic [1:0]  fetch_err,
    output logic        busy,
    output logic        mem_arvalid,
    output logic [31:0] mem_araddr,
    input  logic        mem_arready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    output logic        mem_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_HOLD,
        S_DRAIN
    } state_e;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_BUS     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("inst_fetch: TIMEOUT_CYCLES must be in 1..255");
    end

    state_e      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [1:0]  fetch_err_q, fetch_err_d;
    logic        busy_q, busy_d;
    logic        arvalid_q, arvalid_d;
    logic [31:0] araddr_q, araddr_d;
    logic        rready_q, rready_d;
    logic        tmo_hit;

`ifdef INST_FETCH_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_q, tmo_d;

    // Watchdog counts ADDR+DATA cycles; idle time keeps it at zero so ADDR is entered with 0.
    always_comb begin
        tmo_d = tmo_q;
        if (flush || state_q == S_IDLE) begin
            tmo_d = '0;
        end else if (state_q == S_ADDR || state_q == S_DATA) begin
            tmo_d = tmo_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_hit = (tmo_q == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            inst_q       <= NOP_INST;
            inst_pc_q    <= RESET_VECTOR;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= ERR_OK;
            busy_q       <= 1'b0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            rready_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            fetch_err_q  <= fetch_err_d;
            busy_q       <= busy_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            rready_q     <= rready_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        fetch_err_d  = fetch_err_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        rready_d     = rready_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_req && !flush) begin
                    inst_pc_d = pc;
                    if (pc[1:0] != 2'b00) begin
                        state_d      = S_HOLD;
                        fetch_err_d  = ERR_ALIGN;
                        inst_d       = NOP_INST;
                        inst_valid_d = 1'b1;
                    end else begin
                        araddr_d  = {pc[31:2], 2'b00};
                        arvalid_d = 1'b1;
                        state_d   = S_ADDR;
                    end
                end
            end
            // An address already presented cannot be retracted, so a flush here drains instead.
            S_ADDR: begin
                if (mem_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = flush ? S_DRAIN : S_DATA;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end else if (tmo_hit) begin
                    arvalid_d    = 1'b0;
                    rready_d     = 1'b0;
                    fetch_err_d  = ERR_TIMEOUT;
                    inst_d       = NOP_INST;
                    inst_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_DATA: begin
                if (mem_rvalid) begin
                    rready_d = 1'b0;
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d      = S_HOLD;
                        inst_valid_d = 1'b1;
                        if (mem_rresp != 2'b00) begin
                            fetch_err_d = ERR_BUS;
                            inst_d      = NOP_INST;
                        end else begin
                            fetch_err_d = ERR_OK;
                            inst_d      = mem_rdata;
                        end
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end else if (tmo_hit) begin
                    rready_d     = 1'b0;
                    fetch_err_d  = ERR_TIMEOUT;
                    inst_d       = NOP_INST;
                    inst_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    inst_valid_d = 1'b0;
                    inst_d       = NOP_INST;
                    state_d      = S_IDLE;
                end else if (inst_ack) begin
                    inst_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            // Finish whichever handshake is still outstanding and throw the data away.
            S_DRAIN: begin
                if (arvalid_q) begin
                    if (mem_arready) begin
                        arvalid_d = 1'b0;
                        rready_d  = 1'b1;
                    end
                end else if (mem_rvalid) begin
                    rready_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign inst_valid  = inst_valid_q;
    assign fetch_err   = fetch_err_q;
    assign busy        = busy_q;
    assign mem_arvalid = arvalid_q;
    assign mem_araddr  = araddr_q;
    assign mem_rready  = rready_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: vector table, directed reset/flush sequences, randomized fetches vs a transaction-level model.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = '0;
    logic        fetch_req = 1'b0;
    logic        flush = 1'b0;
    logic        inst_ack = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic [1:0]  fetch_err;
    logic        busy;
    logic        mem_arvalid;
    logic [31:0] mem_araddr;
    logic        mem_arready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [1:0]  mem_rresp = '0;
    logic        mem_rready;

    inst_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .fetch_req  (fetch_req),
        .flush      (flush),
        .inst_ack   (inst_ack),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .fetch_err  (fetch_err),
        .busy       (busy),
        .mem_arvalid(mem_arvalid),
        .mem_araddr (mem_araddr),
        .mem_arready(mem_arready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_rresp  (mem_rresp),
        .mem_rready (mem_rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Slave memory: ar_wait / r_wait are the number of stall cycles before arready / rvalid.
    int          ar_wait = 0;
    int          r_wait  = 0;
    logic [31:0] rdata_cfg = '0;
    logic [1:0]  rresp_cfg = '0;
    int          ar_cnt = 0, r_cnt = 0, pending = 0, ar_hs = 0, r_hs = 0;
    logic        ar_prev = 1'b0, rr_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            ar_cnt = 0; r_cnt = 0; pending = 0;
            mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rresp = 2'b00;
        end else begin
            if (mem_arready && ar_prev) begin pending++; ar_cnt = 0; r_cnt = 0; ar_hs++; end
            if (mem_rvalid && rr_prev) begin pending--; r_cnt = 0; r_hs++; end
            mem_arready = mem_arvalid && (ar_cnt >= ar_wait);
            if (mem_arvalid && !mem_arready) ar_cnt++;
            mem_rvalid = (pending > 0) && (r_cnt >= r_wait);
            if (pending > 0 && !mem_rvalid) r_cnt++;
            mem_rdata = rdata_cfg;
            mem_rresp = mem_rvalid ? rresp_cfg : 2'b00;
        end
        ar_prev = mem_arvalid;
        rr_prev = mem_rready;
    end

    // Transaction-level expectation for one fetch.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                                      input int aw, input int rw,
                                      output logic [31:0] e_inst, output logic [1:0] e_err, output int e_lat);
        if (a % 4 != 0) begin
            e_inst = NOP; e_err = 2'd1; e_lat = 1;
        end else begin
            e_lat = 3 + aw + rw;
            if (resp != 0) begin e_inst = NOP; e_err = 2'd2; end
            else begin e_inst = d; e_err = 2'd0; end
        end
    endfunction

    // Entered and left at posedge+#1 with the DUT idle.
    task automatic run_fetch(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                             input int aw, input int rw,
                             input logic [31:0] e_inst, input logic [1:0] e_err, input int e_lat);
        int   lat;
        logic ar_seen, addr_ok;
        logic [31:0] exp_addr;
        exp_addr = a & ~32'h3;
        ar_wait = aw; r_wait = rw; rdata_cfg = d; rresp_cfg = resp;
        @(negedge clk);
        pc = a; fetch_req = 1'b1;
        lat = 0; ar_seen = 1'b0; addr_ok = 1'b1;
        while (inst_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            fetch_req = 1'b0;
            lat++;
            if (mem_arvalid) begin
                ar_seen = 1'b1;
                if (mem_araddr !== exp_addr) addr_ok = 1'b0;
            end
        end
        check({tag, " valid"}, 32'(inst_valid), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(e_lat));
        check({tag, " inst"}, inst, e_inst);
        check({tag, " inst_pc"}, inst_pc, a);
        check({tag, " fetch_err"}, 32'(fetch_err), 32'(e_err));
        check({tag, " bus_access"}, 32'(ar_seen), 32'(a % 4 == 0));
        check({tag, " araddr_stable"}, 32'(addr_ok), 32'd1);
        repeat (2) begin @(posedge clk); #1; end
        check({tag, " held_valid"}, 32'(inst_valid), 32'd1);
        check({tag, " held_inst"}, inst, e_inst);
        @(negedge clk);
        inst_ack = 1'b1;
        @(posedge clk); #1;
        inst_ack = 1'b0;
        check({tag, " ack_valid"}, 32'(inst_valid), 32'd0);
        check({tag, " ack_busy"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          aw;
        int          rw;
        logic [31:0] exp_inst;
        logic [1:0]  exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int   hs_ar, hs_r, guard;
        logic saw_valid;
        logic [31:0] ra, rd, ei;
        logic [1:0]  rr, ee;
        int   raw, rrw, el;

        vecs[0] = '{32'h0000_0200, 32'h00A0_0093, 2'b00, 0, 0, 32'h00A0_0093, 2'b00, 3};
        // arready arrives in the fourth arvalid cycle, rvalid three stalls later
        vecs[1] = '{32'h0000_0300, 32'h1234_5678, 2'b00, 3, 3, 32'h1234_5678, 2'b00, 9};
        vecs[2] = '{32'h0000_0202, 32'h5555_5555, 2'b00, 0, 0, NOP,           2'b01, 1};
        vecs[3] = '{32'h0000_0400, 32'hDEAD_BEEF, 2'b10, 0, 0, NOP,           2'b10, 3};
        vecs[4] = '{32'hFFFF_FFFC, 32'hCAFE_F00D, 2'b00, 1, 0, 32'hCAFE_F00D, 2'b00, 4};
        vecs[5] = '{32'h0000_0503, 32'h7777_7777, 2'b01, 2, 0, NOP,           2'b01, 1};
        vecs[6] = '{32'h0000_0604, 32'h0BAD_0BAD, 2'b11, 0, 2, NOP,           2'b10, 5};

        repeat (3) @(posedge clk);
        #1;
        check("reset inst", inst, NOP);
        check("reset inst_pc", inst_pc, 32'h0);
        check("reset valid", 32'(inst_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset arvalid", 32'(mem_arvalid), 32'd0);
        check("reset fetch_err", 32'(fetch_err), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_fetch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].rdata, vecs[i].rresp,
                      vecs[i].aw, vecs[i].rw, vecs[i].exp_inst, vecs[i].exp_err, vecs[i].exp_lat);
        end

        // Reset while waiting for read data
        ar_wait = 0; r_wait = 30;
        @(negedge clk);
        pc = 32'h0000_0600; fetch_req = 1'b1;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        @(posedge clk); #1;
        check("rst_mid rready_before", 32'(mem_rready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_mid inst", inst, NOP);
        check("rst_mid inst_pc", inst_pc, 32'h0);
        check("rst_mid valid", 32'(inst_valid), 32'd0);
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid rready", 32'(mem_rready), 32'd0);
        check("rst_mid araddr", mem_araddr, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        run_fetch("after_rst", 32'h0000_0100, 32'h0000_0513, 2'b00, 0, 0, 32'h0000_0513, 2'b00, 3);

        // Flush during the address phase: both handshakes still complete, nothing delivered
        ar_wait = 2; r_wait = 2; hs_ar = ar_hs; hs_r = r_hs;
        @(negedge clk);
        pc = 32'h0000_0700; fetch_req = 1'b1;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        saw_valid = 1'b0; guard = 0;
        while (busy && guard < 40) begin
            saw_valid |= inst_valid;
            @(posedge clk); #1;
            guard++;
        end
        check("flush_addr back_idle", 32'(busy), 32'd0);
        repeat (2) begin @(posedge clk); #1; saw_valid |= inst_valid; end
        check("flush_addr never_valid", 32'(saw_valid), 32'd0);
        check("flush_addr ar_hs", 32'(ar_hs - hs_ar), 32'd1);
        check("flush_addr r_hs", 32'(r_hs - hs_r), 32'd1);
        check("flush_addr drain_cycles", 32'(guard), 32'd5);

        // Flush in DATA coinciding with rvalid: straight back to IDLE
        ar_wait = 0; r_wait = 0; hs_r = r_hs;
        @(negedge clk);
        pc = 32'h0000_0800; fetch_req = 1'b1;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        @(posedge clk); #1;
        check("flush_data in_data", 32'(mem_rready), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_data busy", 32'(busy), 32'd0);
        check("flush_data valid", 32'(inst_valid), 32'd0);
        check("flush_data rready", 32'(mem_rready), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        check("flush_data r_hs", 32'(r_hs - hs_r), 32'd1);

        // Flush together with ack in HOLD
        rdata_cfg = 32'h1111_1111; rresp_cfg = 2'b00;
        @(negedge clk);
        pc = 32'h0000_0900; fetch_req = 1'b1;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("flush_hold pre_inst", inst, 32'h1111_1111);
        @(negedge clk);
        flush = 1'b1; inst_ack = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; inst_ack = 1'b0;
        check("flush_hold valid", 32'(inst_valid), 32'd0);
        check("flush_hold inst", inst, NOP);
        check("flush_hold busy", 32'(busy), 32'd0);

        // Flush in IDLE masks a fetch request
        @(negedge clk);
        pc = 32'h0000_0A00; fetch_req = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        fetch_req = 1'b0; flush = 1'b0;
        check("flush_idle busy", 32'(busy), 32'd0);
        check("flush_idle arvalid", 32'(mem_arvalid), 32'd0);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            rd = $urandom;
            rr = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            raw = $urandom_range(0, 4);
            rrw = $urandom_range(0, 4);
            ref_model(ra, rd, rr, raw, rrw, ei, ee, el);
            run_fetch($sformatf("rnd%0d", i), ra, rd, rr, raw, rrw, ei, ee, el);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
